// File: rtl/tap_recorder.sv
// Cassette write-line recorder: measures falling-edge periods of cass_write and stores
// them as a TAP v1 image in DDRAM through a single-outstanding write handshake.
module tap_recorder #(
    parameter logic [24:0] BASE_ADDR  = 25'h0,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [23:0] MAX_BYTES  = 24'h7FFFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce_1m,
    input  logic        cass_motor_n,
    input  logic        cass_write,
    input  logic        rec_start,
    input  logic        rec_stop,
    output logic [24:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic        wr_req,
    input  logic        wr_ack,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [23:0] tap_len
);

    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_HDR   = 3'd1;
    localparam logic [2:0] S_REC   = 3'd2;
    localparam logic [2:0] S_FLUSH = 3'd3;
    localparam logic [2:0] S_LEN   = 3'd4;

    logic [2:0]  state;
    logic [4:0]  hdr_idx;
    logic [1:0]  len_idx;
    logic        stop_pend;
    logic [23:0] timer;
    logic        prev_wr;
    logic        armed;
    logic [23:0] fifo_mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [2:0]  enc_left;
    logic [23:0] enc_rest;

    logic        fifo_empty, fifo_full, capture, edge_take, push;
    logic        long_code, fits;
    logic [23:0] timer_inc, head;
    logic [2:0]  code_len;

    function automatic logic [7:0] hdr_byte(input logic [4:0] idx);
        case (idx)
            5'd0:    hdr_byte = 8'h43;
            5'd1:    hdr_byte = 8'h36;
            5'd2:    hdr_byte = 8'h34;
            5'd3:    hdr_byte = 8'h2D;
            5'd4:    hdr_byte = 8'h54;
            5'd5:    hdr_byte = 8'h41;
            5'd6:    hdr_byte = 8'h50;
            5'd7:    hdr_byte = 8'h45;
            5'd8:    hdr_byte = 8'h2D;
            5'd9:    hdr_byte = 8'h52;
            5'd10:   hdr_byte = 8'h41;
            5'd11:   hdr_byte = 8'h57;
            5'd12:   hdr_byte = 8'h01;
            5'd13:   hdr_byte = 8'h03;
            default: hdr_byte = 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] len_byte(input logic [1:0] idx, input logic [23:0] len);
        case (idx)
            2'd0:    len_byte = len[7:0];
            2'd1:    len_byte = len[15:8];
            2'd2:    len_byte = len[23:16];
            default: len_byte = 8'h00;
        endcase
    endfunction

    assign busy       = (state != S_IDLE);
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign capture    = ((state == S_HDR) && !stop_pend) || (state == S_REC);
    assign edge_take  = capture && ce_1m && prev_wr && !cass_write && !rec_stop;
    assign push       = edge_take && armed && !fifo_full;

    // The edge tick itself counts toward the period, so the pushed value includes it.
    assign timer_inc  = (ce_1m && !cass_motor_n && (timer != 24'hFFFFFF)) ? timer + 24'd1 : timer;

    assign head      = fifo_mem[rd_ptr[AW-1:0]];
    assign long_code = (head[23:3] == 21'd0) || (head[23:11] != 13'd0);
    assign code_len  = long_code ? 3'd4 : 3'd1;
    assign fits      = ({1'b0, tap_len} + 25'(code_len)) <= {1'b0, MAX_BYTES};

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr[AW-1:0]] <= timer_inc;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            hdr_idx   <= '0;
            len_idx   <= '0;
            stop_pend <= 1'b0;
            timer     <= '0;
            prev_wr   <= 1'b0;
            armed     <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            enc_left  <= '0;
            enc_rest  <= '0;
            wr_addr   <= '0;
            wr_data   <= '0;
            wr_req    <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            tap_len   <= '0;
        end else begin
            done <= 1'b0;
            if (ce_1m)
                prev_wr <= cass_write;

            // First edge after start only arms; later edges deliver a period.
            if (capture) begin
                if (edge_take) begin
                    timer <= '0;
                    if (!armed)
                        armed <= 1'b1;
                    else if (fifo_full)
                        err <= 1'b1;
                end else begin
                    timer <= timer_inc;
                end
            end
            if (push)
                wr_ptr <= wr_ptr + 1'b1;

            if (wr_req && wr_ack)
                wr_req <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (rec_start) begin
                        state     <= S_HDR;
                        hdr_idx   <= '0;
                        stop_pend <= 1'b0;
                        tap_len   <= '0;
                        err       <= 1'b0;
                        armed     <= 1'b0;
                        timer     <= '0;
                        wr_ptr    <= '0;
                        rd_ptr    <= '0;
                        enc_left  <= '0;
                    end
                end
                S_HDR: begin
                    if (rec_stop)
                        stop_pend <= 1'b1;
                    if (!wr_req) begin
                        wr_req  <= 1'b1;
                        wr_addr <= BASE_ADDR + 25'(hdr_idx);
                        wr_data <= hdr_byte(hdr_idx);
                    end else if (wr_ack) begin
                        if (hdr_idx == 5'd19)
                            state <= (stop_pend || rec_stop) ? S_FLUSH : S_REC;
                        else
                            hdr_idx <= hdr_idx + 5'd1;
                    end
                end
                S_REC, S_FLUSH: begin
                    if ((state == S_REC) && rec_stop)
                        state <= S_FLUSH;
                    if (wr_req) begin
                        if (wr_ack) begin
                            enc_left <= enc_left - 3'd1;
                            tap_len  <= tap_len + 24'd1;
                        end
                    end else if (enc_left != 3'd0) begin
                        wr_req   <= 1'b1;
                        wr_addr  <= BASE_ADDR + 25'd20 + 25'(tap_len);
                        wr_data  <= enc_rest[7:0];
                        enc_rest <= enc_rest >> 8;
                    end else if (fifo_empty) begin
                        if (state == S_FLUSH) begin
                            state   <= S_LEN;
                            len_idx <= '0;
                        end
                    // A code that would overrun capacity ends the take without partial bytes.
                    end else if (fits) begin
                        rd_ptr   <= rd_ptr + 1'b1;
                        enc_left <= code_len;
                        enc_rest <= head;
                        wr_req   <= 1'b1;
                        wr_addr  <= BASE_ADDR + 25'd20 + 25'(tap_len);
                        wr_data  <= long_code ? 8'h00 : head[10:3];
                    end else begin
                        err     <= 1'b1;
                        wr_ptr  <= '0;
                        rd_ptr  <= '0;
                        state   <= S_LEN;
                        len_idx <= '0;
                    end
                end
                S_LEN: begin
                    if (!wr_req) begin
                        wr_req  <= 1'b1;
                        wr_addr <= BASE_ADDR + 25'd16 + 25'(len_idx);
                        wr_data <= len_byte(len_idx, tap_len);
                    end else if (wr_ack) begin
                        if (len_idx == 2'd3) begin
                            state <= S_IDLE;
                            done  <= 1'b1;
                        end else begin
                            len_idx <= len_idx + 2'd1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
